// File: rtl/fetch.sv
// Instruction fetch unit: issues sequential word fetches on a req/ack memory
// port, buffers returned words in a 2-entry FIFO and streams {pc, word} to
// decode. A redirect restarts fetch at a new PC, flushing buffered words and
// dropping any response that is still in flight.
//
// Handshakes:
//   imem side  - imem_req/imem_addr are registered and held until the cycle
//                with imem_ack=1; imem_rdata is taken in that same cycle.
//   decode side - insn_valid/insn/insn_pc come straight from the FIFO head
//                registers; a transfer (pop) happens on every rising edge
//                where insn_valid & insn_ready. insn_valid never depends on
//                insn_ready combinationally.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        insn_valid,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    input  logic        insn_ready,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [31:0] pc;
    logic [31:0] pc_d;
    logic [31:0] addr_d;
    logic        drop;
    logic        drop_d;
    logic        fault_d;

    // FIFO: head lives in insn/insn_pc, second entry in tail_*.
    logic [1:0]  count;
    logic [31:0] tail_pc;
    logic [31:0] tail_word;

    logic        pop;
    logic        push;
    logic        flush;
    logic        misaligned;
    logic [1:0]  count_after_pop;

    assign insn_valid      = (count != 2'd0);
    assign pop             = insn_valid & insn_ready;
    assign flush           = redirect;
    assign misaligned      = (redirect_pc[1:0] != 2'b00);
    assign count_after_pop = count - {1'b0, pop};

    // Next-state logic: redirect overrides everything; otherwise issue a new
    // request whenever the FIFO is guaranteed room for its response.
    always_comb begin
        state_d = state;
        pc_d    = pc;
        addr_d  = imem_addr;
        drop_d  = drop;
        fault_d = fault;
        push    = 1'b0;
        if (redirect) begin
            pc_d    = redirect_pc;
            fault_d = misaligned;
            if (state == ST_BUSY && !imem_ack) begin
                // Response still owed: keep the address stable, throw the
                // word away when it arrives, decide where to go after that.
                drop_d = 1'b1;
            end else begin
                drop_d  = 1'b0;
                state_d = misaligned ? ST_FAULT : ST_IDLE;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (count_after_pop < 2'd2) begin
                        state_d = ST_BUSY;
                        addr_d  = pc;
                        pc_d    = pc + 32'd4;
                    end
                end
                ST_BUSY: begin
                    if (imem_ack) begin
                        push   = ~drop;
                        drop_d = 1'b0;
                        if (fault) begin
                            // Misaligned redirect was waiting on this ack.
                            state_d = ST_FAULT;
                        end else if ((count_after_pop + {1'b0, ~drop}) < 2'd2) begin
                            addr_d = pc;
                            pc_d   = pc + 32'd4;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Control registers: state, pc, request address/strobe, drop and fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            imem_addr <= RESET_PC;
            imem_req  <= 1'b0;
            drop      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            imem_addr <= addr_d;
            imem_req  <= (state_d == ST_BUSY);
            drop      <= drop_d;
            fault     <= fault_d;
        end
    end

    // FIFO update: flush wins; otherwise shift on pop and write the acked
    // word into the first free slot after any pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            insn      <= 32'd0;
            insn_pc   <= 32'd0;
            tail_word <= 32'd0;
            tail_pc   <= 32'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b01: begin
                    insn    <= tail_word;
                    insn_pc <= tail_pc;
                    count   <= count - 2'd1;
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        insn    <= imem_rdata;
                        insn_pc <= imem_addr;
                    end else begin
                        tail_word <= imem_rdata;
                        tail_pc   <= imem_addr;
                    end
                    count <= count + 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        insn    <= imem_rdata;
                        insn_pc <= imem_addr;
                    end else begin
                        insn      <= tail_word;
                        insn_pc   <= tail_pc;
                        tail_word <= imem_rdata;
                        tail_pc   <= imem_addr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Bench for the fetch unit: a memory model with tied or delayed ack, a
// scoreboard of expected fetch PCs consumed on every decode transfer, and
// one task per scenario with inline checks.
module tb_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        insn_valid;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_ready;
    logic        fault;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

    logic ack_tied = 1'b0;
    int   mem_wait = 0;
    int   wait_cnt = 0;

    fetch #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .insn_valid  (insn_valid),
        .insn        (insn),
        .insn_pc     (insn_pc),
        .insn_ready  (insn_ready),
        .fault       (fault)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_fn(imem_addr);

    // Memory model: ack tied high, or ack after mem_wait wait cycles.
    always @(posedge clk) begin
        #1;
        if (ack_tied) begin
            imem_ack = 1'b1;
            wait_cnt = 0;
        end else if (imem_req) begin
            if (wait_cnt >= mem_wait) begin
                imem_ack = 1'b1;
                wait_cnt = 0;
            end else begin
                imem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    // Scoreboard: every decode transfer outside a redirect cycle must match
    // the next expected PC and the memory word at that PC.
    always @(negedge clk) begin
        if (rst_n && dut.push && dut.count == 2'd2) begin
            total++;
            bad++;
            $display("FAIL fifo_overflow push while count=2");
        end
        if (rst_n && insn_valid && insn_ready && !redirect) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra got pc=%h insn=%h, required no transfer", insn_pc, insn);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (insn_pc !== e || insn !== mem_fn(e)) begin
                    bad++;
                    $display("FAIL sb_word got pc=%h insn=%h, required pc=%h insn=%h",
                             insn_pc, insn, e, mem_fn(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b required=0", imem_req); end
        total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL rst_addr got=%h required=%h", imem_addr, RESET_PC); end
        total++; if (insn_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b required=0", insn_valid); end
        total++; if (insn !== 32'd0) begin bad++; $display("FAIL rst_insn got=%h required=0", insn); end
        total++; if (insn_pc !== 32'd0) begin bad++; $display("FAIL rst_insn_pc got=%h required=0", insn_pc); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b required=0", fault); end
    endtask

    task automatic test_stream();
        int n;
        ack_tied   = 1'b1;
        insn_ready = 1'b1;
        for (int k = 0; k < 12; k++) exp_q.push_back(RESET_PC + 32'(4 * k));
        rst_n = 1'b1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL first_req_early got=%b required=0", imem_req); end
        tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            bad++; $display("FAIL first_req got req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
        n = 1;
        while (exp_q.size() != 0 && n < 40) begin tick(); n++; end
        total++;
        if (n != 14 || exp_q.size() != 0) begin
            bad++; $display("FAIL stream_rate got cycles=%0d left=%0d required cycles=14 left=0", n, exp_q.size());
            exp_q.delete();
        end
        insn_ready = 1'b0;
    endtask

    task automatic test_stall();
        int n;
        for (int k = 0; k < 8; k++) exp_q.push_back(32'h130 + 32'(4 * k));
        for (int c = 1; c <= 5; c++) begin
            tick();
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req cycle=%0d got=%b required=0", c, imem_req); end
        end
        total++;
        if (insn_valid !== 1'b1 || insn_pc !== 32'h130) begin
            bad++; $display("FAIL stall_head got valid=%b pc=%h required valid=1 pc=00000130", insn_valid, insn_pc);
        end
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_last got=%b required=0", imem_req); end
        insn_ready = 1'b1;
        tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h138) begin
            bad++; $display("FAIL stall_resume got req=%b addr=%h required req=1 addr=00000138", imem_req, imem_addr);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin tick(); n++; end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stall_drain left=%0d required=0", exp_q.size()); exp_q.delete(); end
        insn_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        int n;
        repeat (4) tick();
        ack_tied = 1'b0;
        mem_wait = 3;
        tick();
        exp_q.push_back(32'h180);
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        redirect    = 1'b1;
        redirect_pc = 32'h180;
        insn_ready  = 1'b1;
        tick();
        redirect = 1'b0;
        tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h180) begin
            bad++; $display("FAIL rdw_first got req=%b addr=%h required req=1 addr=00000180", imem_req, imem_addr);
        end
        repeat (5) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h184) begin
            bad++; $display("FAIL rdw_hold1 got req=%b addr=%h required req=1 addr=00000184", imem_req, imem_addr);
        end
        tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h184) begin
            bad++; $display("FAIL rdw_hold2 got req=%b addr=%h required req=1 addr=00000184", imem_req, imem_addr);
        end
        tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            bad++; $display("FAIL rdw_next got req=%b addr=%h required req=1 addr=00000200", imem_req, imem_addr);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin tick(); n++; end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rdw_drain left=%0d required=0", exp_q.size()); exp_q.delete(); end
        insn_ready = 1'b0;
    endtask

    task automatic test_redirect_ack_pop();
        int n;
        ack_tied = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(32'h380 + 32'(4 * k));
        redirect    = 1'b1;
        redirect_pc = 32'h380;
        insn_ready  = 1'b1;
        tick();
        redirect = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin tick(); n++; end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rap_setup left=%0d required=0", exp_q.size()); exp_q.delete(); end
        for (int k = 0; k < 3; k++) exp_q.push_back(32'h400 + 32'(4 * k));
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        tick();
        redirect = 1'b0;
        total++; if (insn_valid !== 1'b0) begin bad++; $display("FAIL rap_flush got valid=%b required=0", insn_valid); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rap_idle got req=%b required=0", imem_req); end
        tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin
            bad++; $display("FAIL rap_next got req=%b addr=%h required req=1 addr=00000400", imem_req, imem_addr);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin tick(); n++; end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rap_drain left=%0d required=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_fault();
        int n;
        redirect    = 1'b1;
        redirect_pc = 32'h202;
        tick();
        redirect = 1'b0;
        for (int c = 0; c < 4; c++) begin
            total++;
            if (fault !== 1'b1 || imem_req !== 1'b0 || insn_valid !== 1'b0) begin
                bad++; $display("FAIL fault_hold cycle=%0d got fault=%b req=%b valid=%b required 1 0 0",
                                c, fault, imem_req, insn_valid);
            end
            if (c < 3) tick();
        end
        exp_q.push_back(32'h300);
        exp_q.push_back(32'h304);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        total++;
        if (fault !== 1'b0 || imem_req !== 1'b0) begin
            bad++; $display("FAIL fault_clear got fault=%b req=%b required 0 0", fault, imem_req);
        end
        tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            bad++; $display("FAIL fault_resume got req=%b addr=%h required req=1 addr=00000300", imem_req, imem_addr);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin tick(); n++; end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL fault_drain left=%0d required=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_wrap_and_reset();
        int n;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin tick(); n++; end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_drain left=%0d required=0", exp_q.size()); exp_q.delete(); end
        insn_ready = 1'b0;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL midreq_setup got req=%b required=1", imem_req); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL async_req got=%b required=0", imem_req); end
        total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL async_addr got=%h required=%h", imem_addr, RESET_PC); end
        total++;
        if (insn_valid !== 1'b0 || insn !== 32'd0 || insn_pc !== 32'd0 || fault !== 1'b0) begin
            bad++; $display("FAIL async_outs got valid=%b insn=%h pc=%h fault=%b required all 0",
                            insn_valid, insn, insn_pc, fault);
        end
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            bad++; $display("FAIL rerelease got req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    initial begin
        rst_n       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        insn_ready  = 1'b0;
        imem_ack    = 1'b0;
        #3;
        rst_n = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_ack_pop();
        test_fault();
        test_wrap_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch.md
# fetch

Instruction fetch unit for the RV32I core. Generates sequential word addresses from a program counter and issues them on a request/acknowledge instruction-memory port. Returned words are buffered in a 2-entry FIFO and presented, together with their PC, on a valid/ready stream to the decode stage. A redirect input from execute restarts fetch at a new PC: it flushes buffered words and discards any in-flight response.

## Interface
- `RESET_PC`, default 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `imem_req`  out  1  instruction-memory request, registered.
- `imem_addr`  out  32  word address of the request, registered, stable while `imem_req`=1.
- `imem_ack`  in  1  memory accepts the request; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `redirect`  in  1  restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch target.
- `insn_valid`  out  1  FIFO head is valid.
- `insn`  out  32  FIFO head instruction word.
- `insn_pc`  out  32  address `insn` was fetched from.
- `insn_ready`  in  1  decode accepts the head; a pop occurs when `insn_valid` & `insn_ready`.
- `fault`  out  1  sticky misaligned-redirect flag.

## Operation
- Registers:
  - `pc`: next address to request.
  - FIFO: 2 entries of {pc, word}, with a 2-bit count.
  - `drop` flag.
  - State: IDLE, BUSY, FAULT.
- IDLE:
  - `imem_req`=0.
  - If `redirect`=0 and count−pop < 2: go to BUSY, `imem_addr`←`pc`, `pc`←`pc`+4.
- BUSY:
  - `imem_req`=1. `imem_addr` is held until `imem_ack`.
  - On ack with `drop`=0: push {`imem_addr`, `imem_rdata`}.
  - On ack with `drop`=1: do not push; clear `drop`.
  - After ack, if count−pop+push < 2 and no redirect: stay in BUSY, `imem_addr`←`pc`, `pc`←`pc`+4 (back-to-back).
  - Otherwise go to IDLE.
- The space check guarantees the FIFO never overflows. A push into a full FIFO is a design error; the bench asserts it never happens.
- Redirect, any state, takes priority over all other events in the cycle:
  - FIFO count←0. `insn_valid` drops next cycle; a same-cycle pop is irrelevant.
  - `pc`←`redirect_pc`.
  - If BUSY without `imem_ack` this cycle: set `drop`, stay in BUSY, keep the old `imem_addr`.
  - If BUSY with `imem_ack` this cycle: discard that word, go to IDLE.
  - If `redirect_pc[1:0]`≠0: `fault`←1 and state←FAULT. If a request is outstanding, it still completes and is dropped; the unit enters FAULT after that ack.
- FAULT:
  - `imem_req`=0, no pushes, `insn_valid`=0.
  - Left only by a redirect with an aligned target, which clears `fault` and goes to IDLE.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Reset (asynchronous, may occur mid-transaction):
  - `pc`=`RESET_PC`, state IDLE, count 0, `drop`=0.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `insn_valid`=0, `insn`=0, `insn_pc`=0, `fault`=0.
  - An outstanding request is abandoned; the memory must tolerate `imem_req` falling before ack.

## Timing
- First request: `imem_req`=1 in the first cycle after the first clock edge following `rst_n` release.
- Latency: the ack cycle is N; `insn_valid`=1 with that word at N+1.
- Throughput: with zero-wait memory (ack tied high) and `insn_ready`=1, one instruction per cycle sustained. PCs are consecutive +4.
- Stalls:
  - Decode stall: the FIFO fills to 2, then `imem_req` drops the cycle after the second push.
  - Fetch resumes one cycle after the pop that frees space (IDLE→BUSY).
- Redirect at cycle R with no outstanding request: new `imem_addr`=`redirect_pc` with `imem_req`=1 at R+2.
- Outputs `insn`/`insn_pc` are the FIFO head registers. No combinational path exists from `insn_ready` to `insn_valid`, or from `imem_ack` to `imem_req`/`imem_addr`.

## Test plan
- Reset release, `RESET_PC`=32'h100, ack tied 1, ready 1 → `insn_pc` sequence 100,104,108,… one per cycle; `insn` equals the memory contents at each address.
- `insn_ready`=0 for 6 cycles with zero-wait memory → exactly 2 words are buffered, `imem_req` is low for the rest of the stall, no word is lost or duplicated when ready rises.
- Memory ack delayed 3 cycles; `redirect` to 32'h200 in the second wait cycle → `imem_addr` stays at the old address until ack, that word never appears on `insn`, next request is 32'h200.
- `redirect` in the same cycle as `imem_ack` and a pop → the FIFO is empty the next cycle, the acked word is discarded, the first post-redirect `insn_pc`=`redirect_pc`.
- `redirect_pc`=32'h202 → `fault`=1, `imem_req`=0, `insn_valid`=0 held. A later redirect to 32'h300 clears `fault` and fetch resumes at 300.
- `pc` at 32'hFFFF_FFF8 with ready 1 → `insn_pc` FFFF_FFF8, FFFF_FFFC, 0000_0000; `rst_n` asserted mid-request → all outputs at their reset values immediately.
